// File: rtl/seq_bin2bcd_7seg_pkg.sv
// Shared types and constants for the sequential binary-to-BCD 7-segment converter.
package seq_bin2bcd_7seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

    // Active-low segment patterns, bit order g..a
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Codes 10-15 never come out of the shift-add-3 datapath; show them dark.
    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seq_bin2bcd_7seg_dec.sv
// One BCD digit to active-low 7-segment pattern, with forced-dark input.
module seg7_digit_dec
    import seq_bin2bcd_7seg_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blank overrides the digit pattern
    always_comb begin
        seg_o = blank_i ? SEG_BLANK : seg_pattern(digit_i);
    end

endmodule

// File: rtl/seq_bin2bcd_7seg.sv
// Iterative shift-add-3 binary-to-BCD converter driving DIGITS active-low 7-seg displays.
//
//  state     | meaning
//  ST_IDLE   | waiting for start_i; outputs hold the last result
//  ST_SHIFT  | WIDTH cycles of add-3 correction plus one-bit shift
//  ST_UPDATE | result just loaded into outputs, done_o high for this cycle
module seq_bin2bcd_7seg
    import seq_bin2bcd_7seg_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int DIGITS   = 2,
    parameter int BLANK_LZ = 0
)(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [7*DIGITS-1:0]   hex_o
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e                state_q;
    logic [AW-1:0]         acc_q;
    logic [AW-1:0]         acc_adj;
    logic [AW-1:0]         acc_d;
    logic [WIDTH-1:0]      bin_q;
    logic [WIDTH-1:0]      bin_d;
    logic [CW-1:0]         cnt_q;
    logic                  sticky_q;
    logic                  sticky_d;
    logic                  busy_q;
    logic                  done_q;
    logic                  overflow_q;
    logic [AW-1:0]         bcd_q;
    logic [7*DIGITS-1:0]   hex_q;
    logic [7*DIGITS-1:0]   hex_d;
    logic [7*DIGITS-1:0]   dec_seg;
    logic [DIGITS-1:0]     blank;

    // Add-3 correction on every digit in parallel, then shift {acc,bin} left one bit
    always_comb begin
        logic [AW+WIDTH-1:0] cat;
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        cat      = {acc_adj, bin_q} << 1;
        acc_d    = cat[AW+WIDTH-1 : WIDTH];
        bin_d    = cat[WIDTH-1:0];
        // Anything shifted out of the top digit means the value needs more digits
        sticky_d = sticky_q | acc_adj[AW-1];
    end

    // Leading-zero blanking: digit i>0 dark when it and every higher digit is zero
    always_comb begin
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (acc_d[4*i +: 4] == 4'd0);
            blank[i]   = (BLANK_LZ != 0) && zero_above;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_digit_dec u_dec (
            .digit_i (acc_d[4*g +: 4]),
            .blank_i (blank[g]),
            .seg_o   (dec_seg[7*g +: 7])
        );
    end

    // Overflow replaces every display with a dash
    always_comb begin
        hex_d = dec_seg;
        if (sticky_d) begin
            for (int i = 0; i < DIGITS; i++) begin
                hex_d[7*i +: 7] = SEG_DASH;
            end
        end
    end

    // Control FSM with registered outputs; results load on the last shift so they
    // are valid in the same cycle done_o is high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
            hex_q      <= '1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        bin_q    <= bin_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        sticky_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc_q    <= acc_d;
                    bin_q    <= bin_d;
                    sticky_q <= sticky_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        bcd_q      <= acc_d;
                        overflow_q <= sticky_d;
                        hex_q      <= hex_d;
                        state_q    <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overflow_o = overflow_q;
    assign bcd_o      = bcd_q;
    assign hex_o      = hex_q;

endmodule

// File: tb/tb_seq_bin2bcd_7seg.sv
// Directed bench for seq_bin2bcd_7seg across four parameter sets sharing one stimulus bus.
module tb_seq_bin2bcd_7seg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin = '0;

    // defaults: WIDTH=6 DIGITS=2 BLANK_LZ=0
    logic        def_busy, def_done, def_ovf;
    logic [7:0]  def_bcd;
    logic [13:0] def_hex;
    // WIDTH=6 DIGITS=2 BLANK_LZ=1
    logic        blk_busy, blk_done, blk_ovf;
    logic [7:0]  blk_bcd;
    logic [13:0] blk_hex;
    // WIDTH=8 DIGITS=2
    logic        w8_busy, w8_done, w8_ovf;
    logic [7:0]  w8_bcd;
    logic [13:0] w8_hex;
    // WIDTH=10 DIGITS=4
    logic        w10_busy, w10_done, w10_ovf;
    logic [15:0] w10_bcd;
    logic [27:0] w10_hex;

    int n_checks = 0;
    int n_err    = 0;

    int busy_cnt, def_done_n, def_done_cyc, w10_done_n, w10_done_cyc, w8_done_n;

    always #5 clk = ~clk;

    seq_bin2bcd_7seg u_def (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bin_i(bin[5:0]),
        .busy_o(def_busy), .done_o(def_done), .overflow_o(def_ovf),
        .bcd_o(def_bcd), .hex_o(def_hex));

    seq_bin2bcd_7seg #(.WIDTH(6), .DIGITS(2), .BLANK_LZ(1)) u_blk (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bin_i(bin[5:0]),
        .busy_o(blk_busy), .done_o(blk_done), .overflow_o(blk_ovf),
        .bcd_o(blk_bcd), .hex_o(blk_hex));

    seq_bin2bcd_7seg #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(0)) u_w8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bin_i(bin[7:0]),
        .busy_o(w8_busy), .done_o(w8_done), .overflow_o(w8_ovf),
        .bcd_o(w8_bcd), .hex_o(w8_hex));

    seq_bin2bcd_7seg #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(0)) u_w10 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bin_i(bin[9:0]),
        .busy_o(w10_busy), .done_o(w10_done), .overflow_o(w10_ovf),
        .bcd_o(w10_bcd), .hex_o(w10_hex));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bcd_ref(input int v, input int digits);
        logic [31:0] r = '0;
        for (int i = 0; i < digits; i++) begin
            r = r | (32'(v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    // One-cycle start pulse, then watch 14 cycles (cycle k = after edge k-1)
    task automatic run(input logic [15:0] val);
        @(negedge clk);
        bin   = val;
        start = 1'b1;
        busy_cnt = 0; def_done_n = 0; def_done_cyc = -1;
        w10_done_n = 0; w10_done_cyc = -1; w8_done_n = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (def_busy) busy_cnt++;
            if (def_done) begin def_done_n++; def_done_cyc = k; end
            if (w10_done) begin w10_done_n++; w10_done_cyc = k; end
            if (w8_done) w8_done_n++;
        end
    endtask

    initial begin
        int sweep_done;
        int held_done_n;
        int held_first;
        int held_second;
        logic [7:0] held_bcd1;
        logic [7:0] held_bcd2;
        logic held_busy8;
        logic held_busy9;
        int rst_done;

        #12;
        check("rst_busy", 32'(def_busy), 32'd0);
        check("rst_done", 32'(def_done), 32'd0);
        check("rst_ovf",  32'(def_ovf),  32'd0);
        check("rst_bcd",  32'(def_bcd),  32'h0);
        check("rst_hex",  32'(def_hex),  32'h3FFF);
        check("rst_hex10", 32'(w10_hex), 32'hFFFFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 45
        run(16'd45);
        check("45_busy_cycles", 32'(busy_cnt), 32'd6);
        check("45_done_cycle",  32'(def_done_cyc), 32'd7);
        check("45_done_count",  32'(def_done_n), 32'd1);
        check("45_bcd",  32'(def_bcd), 32'h45);
        check("45_hex1", 32'(def_hex[13:7]), 32'b0011001);
        check("45_hex0", 32'(def_hex[6:0]),  32'b0010010);
        check("45_ovf",  32'(def_ovf), 32'd0);
        check("45_blk_hex", 32'(blk_hex), {18'd0, 7'b0011001, 7'b0010010});
        check("45_w8_bcd", 32'(w8_bcd), 32'h45);
        check("45_w10_bcd", 32'(w10_bcd), 32'h0045);
        check("45_w10_done_cycle", 32'(w10_done_cyc), 32'd11);

        // 63
        run(16'd63);
        check("63_bcd",  32'(def_bcd), 32'h63);
        check("63_hex1", 32'(def_hex[13:7]), 32'b0000010);
        check("63_hex0", 32'(def_hex[6:0]),  32'b0110000);

        // 0 with and without blanking
        run(16'd0);
        check("0_blk_hex1", 32'(blk_hex[13:7]), 32'h7F);
        check("0_blk_hex0", 32'(blk_hex[6:0]),  32'b1000000);
        check("0_def_hex1", 32'(def_hex[13:7]), 32'b1000000);
        check("0_def_bcd",  32'(def_bcd), 32'h00);

        // 200: overflow on WIDTH=8 DIGITS=2; WIDTH=6 sees 8
        run(16'd200);
        check("200_w8_ovf",  32'(w8_ovf), 32'd1);
        check("200_w8_hex",  32'(w8_hex), {18'd0, 7'b0111111, 7'b0111111});
        check("200_w8_bcd",  32'(w8_bcd), 32'h00);
        check("200_def_bcd", 32'(def_bcd), 32'h08);
        check("200_blk_hex", 32'(blk_hex), {18'd0, 7'h7F, 7'b0000000});
        check("200_w10_bcd", 32'(w10_bcd), 32'h0200);

        // 99 clears overflow
        run(16'd99);
        check("99_w8_ovf", 32'(w8_ovf), 32'd0);
        check("99_w8_bcd", 32'(w8_bcd), 32'h99);
        check("99_w8_hex", 32'(w8_hex), {18'd0, 7'b0010000, 7'b0010000});
        check("99_def_bcd", 32'(def_bcd), 32'h35);

        // start held high, BIN changed mid-run
        @(negedge clk);
        bin = 16'd12;
        start = 1'b1;
        held_done_n = 0; held_first = -1; held_second = -1;
        held_bcd1 = '0; held_bcd2 = '0; held_busy8 = 1'b1; held_busy9 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) bin = 16'd34;
            if (k == 8) held_busy8 = def_busy;
            if (k == 9) begin held_busy9 = def_busy; start = 1'b0; end
            if (def_done) begin
                held_done_n++;
                if (held_first < 0) begin held_first = k; held_bcd1 = def_bcd; end
                else begin held_second = k; held_bcd2 = def_bcd; end
            end
        end
        check("held_first_cycle",  32'(held_first), 32'd7);
        check("held_first_bcd",    32'(held_bcd1), 32'h12);
        check("held_busy_c8",      32'(held_busy8), 32'd0);
        check("held_busy_c9",      32'(held_busy9), 32'd1);
        check("held_second_cycle", 32'(held_second), 32'd15);
        check("held_second_bcd",   32'(held_bcd2), 32'h34);
        check("held_done_count",   32'(held_done_n), 32'd2);

        // reset in 3rd SHIFT cycle
        @(negedge clk);
        bin = 16'd45;
        start = 1'b1;
        rst_done = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (def_done) rst_done++;
        end
        check("mid_busy_before", 32'(def_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(def_busy), 32'd0);
        check("mid_rst_bcd",  32'(def_bcd),  32'h0);
        check("mid_rst_hex",  32'(def_hex),  32'h3FFF);
        check("mid_rst_ovf",  32'(def_ovf),  32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (def_done) rst_done++;
        end
        check("mid_rst_no_done", 32'(rst_done), 32'd0);
        run(16'd57);
        check("post_rst_bcd",  32'(def_bcd), 32'h57);
        check("post_rst_hex",  32'(def_hex), {18'd0, 7'b0010010, 7'b1111000});
        check("post_rst_done", 32'(def_done_n), 32'd1);

        // full sweep on WIDTH=10 DIGITS=4
        sweep_done = 0;
        for (int v = 0; v < 1024; v++) begin
            run(16'(v));
            sweep_done += w10_done_n;
            check($sformatf("sweep_%0d", v), 32'(w10_bcd), bcd_ref(v, 4));
        end
        check("sweep_done_count", 32'(sweep_done), 32'd1024);
        check("sweep_ovf", 32'(w10_ovf), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
